// File: rtl/audio_arbiter.sv
// audio_arbiter: shares one tone driver and note-duration counter among N_REQ jingle
// sequencers. Index 0 has the highest priority. Each note is timed internally, and a
// one-cycle done pulse is returned to the owner only.
// Optional feature macro: AUDIO_ARB_PREEMPT_EN lets a higher-priority requester take the
// grant on the owner's note boundary.
module audio_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned NOTE_CYCLES = 12500000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned RELEASE_GAP = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req_en_i,
  input  logic [7*N_REQ-1:0] req_note_i,
  output logic [N_REQ-1:0]   counter_done_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [6:0]         note_o,
  output logic               note_valid_o,
  output logic               busy_o
);

  localparam int unsigned GAP_W = $clog2(RELEASE_GAP + 1);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [6:0]         note_q, note_d;
  logic               valid_q, valid_d;
  logic               owner_en;
  logic               note_end;
  logic [N_REQ-1:0]   req_low;
  logic [6:0]         owner_note;
`ifdef AUDIO_ARB_PREEMPT_EN
  logic [N_REQ-1:0]   req_above;
  logic [N_REQ-1:0]   above_low;
  logic               preempt;
`endif

  // Owner enable, lowest pending request and end-of-note decode from registered state
  always_comb begin
    owner_en = |(req_en_i & grant_q);
    // x & -x isolates the lowest set bit, i.e. the highest-priority requester
    req_low  = req_en_i & (~req_en_i + N_REQ'(1));
    note_end = (state_q == StPlay) && (cnt_q == CNT_W'(NOTE_CYCLES - 1));
  end

  // Select the owner's note code through the one-hot grant
  always_comb begin
    owner_note = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) owner_note = owner_note | req_note_i[7*k +: 7];
    end
  end

`ifdef AUDIO_ARB_PREEMPT_EN
  // grant - 1 on a one-hot grant masks exactly the higher-priority (lower-index) bits
  always_comb begin
    req_above = req_en_i & (grant_q - N_REQ'(1));
    above_low = req_above & (~req_above + N_REQ'(1));
    preempt   = note_end && (|req_above);
  end
`endif

  // Next-state logic for grant, note counter and release-gap counter
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        gap_d = '0;
        if (|req_en_i) begin
          grant_d = req_low;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (owner_en) begin
          cnt_d = note_end ? '0 : cnt_q + CNT_W'(1);
        end else begin
          state_d = StGap;
          gap_d   = GAP_W'(1);
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (owner_en) begin
          state_d = StPlay;
          cnt_d   = '0;
        end else if (gap_q == GAP_W'(RELEASE_GAP - 1)) begin
          state_d = StIdle;
          grant_d = '0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef AUDIO_ARB_PREEMPT_EN
    if (preempt) begin
      grant_d = above_low;
      state_d = StPlay;
      cnt_d   = '0;
      gap_d   = '0;
    end
`endif
  end

  // Tone-driver outputs lag the internal state by one cycle
  always_comb begin
    valid_d = (state_q == StPlay) && owner_en;
    note_d  = valid_d ? owner_note : 7'd0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      grant_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      note_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      note_q  <= note_d;
      valid_q <= valid_d;
    end
  end

  // Output mapping; the done pulse can only reach the current owner
  always_comb begin
    counter_done_o = note_end ? grant_q : '0;
    grant_o        = grant_q;
    busy_o         = |grant_q;
    note_o         = note_q;
    note_valid_o   = valid_q;
  end

endmodule

// File: tb/tb_audio_arbiter.sv
// Self-checking bench for audio_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the arbitration rules.
module tb_audio_arbiter;

  localparam int N  = 4;
  localparam int NC = 8;
  localparam int RG = 4;

  logic           clk;
  logic           resetn;
  logic [N-1:0]   req_en;
  logic [7*N-1:0] req_note;
  logic [N-1:0]   counter_done_o;
  logic [N-1:0]   grant_o;
  logic [6:0]     note_o;
  logic           note_valid_o;
  logic           busy_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: owner index (-1 when idle), sounding vs between notes, elapsed note cycles
  int       m_owner = -1;
  bit       m_play  = 1'b0;
  int       m_cnt   = 0;
  int       m_gap   = 0;
  bit       m_valid = 1'b0;
  bit [6:0] m_note  = '0;

  audio_arbiter #(
    .N_REQ      (N),
    .NOTE_CYCLES(NC),
    .CNT_W      (4),
    .RELEASE_GAP(RG)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_en_i      (req_en),
    .req_note_i    (req_note),
    .counter_done_o(counter_done_o),
    .grant_o       (grant_o),
    .note_o        (note_o),
    .note_valid_o  (note_valid_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v, input int below);
    for (int i = 0; i < below; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
  endfunction

  function automatic logic [N-1:0] exp_done();
    return (m_owner >= 0 && m_play && m_cnt == NC - 1) ? (N'(1) << m_owner) : '0;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_play = 1'b0; m_cnt = 0; m_gap = 0; m_valid = 1'b0; m_note = '0;
  endtask

  // Apply one clock edge of the arbitration rules using the inputs held before the edge
  task automatic model_edge();
    bit done_now;
    int old_owner;
`ifdef AUDIO_ARB_PREEMPT_EN
    int hi;
`endif
    done_now  = (m_owner >= 0) && m_play && (m_cnt == NC - 1);
    old_owner = m_owner;
    m_valid   = (m_owner >= 0) && m_play && req_en[m_owner];
    m_note    = m_valid ? req_note[7*m_owner +: 7] : 7'd0;
    if (m_owner < 0) begin
      if (req_en != '0) begin m_owner = lowest(req_en, N); m_play = 1'b1; m_cnt = 0; end
    end else if (m_play) begin
      if (req_en[m_owner]) m_cnt = done_now ? 0 : m_cnt + 1;
      else begin m_play = 1'b0; m_gap = 1; m_cnt = 0; end
    end else begin
      if (req_en[m_owner]) begin m_play = 1'b1; m_cnt = 0; end
      else if (m_gap + 1 == RG) m_owner = -1;
      else m_gap++;
    end
`ifdef AUDIO_ARB_PREEMPT_EN
    hi = lowest(req_en, old_owner);
    if (done_now && hi >= 0) begin m_owner = hi; m_play = 1'b1; m_cnt = 0; end
`else
    if (old_owner < -1) m_owner = old_owner;
`endif
  endtask

  // One clock: advance the model, then compare every output 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    if (!resetn) model_reset(); else model_edge();
    cyc++;
    #1;
    chk("grant", 32'(grant_o), 32'(exp_grant()));
    chk("done", 32'(counter_done_o), 32'(exp_done()));
    chk("note", 32'(note_o), 32'(m_note));
    chk("valid", 32'(note_valid_o), 32'(m_valid));
    chk("busy", 32'(busy_o), 32'(m_owner >= 0));
  endtask

  // Behave like a jingle FSM: play n notes, one WAIT cycle after each pulse, then release
  task automatic run_jingle(input int idx, input int n_notes, output int dones,
                            output int rel_steps);
    int start;
    int last;
    dones = 0; rel_steps = -1; last = 0;
    req_en[idx] = 1'b1;
    start = cyc;
    for (int t = 0; t < 400 && dones < n_notes; t++) begin
      step();
      if (counter_done_o[idx]) begin
        dones++;
        if (dones == 1) chk("first_done_latency", 32'(cyc - start), 32'(NC));
        else chk("done_spacing", 32'(cyc - last), 32'(NC + 2));
        last = cyc;
        step();
        req_en[idx] = 1'b0;
        if (dones < n_notes) begin
          step();
          req_en[idx] = 1'b1;
        end
      end
    end
    for (int k = 1; k <= 40; k++) begin
      step();
      if (grant_o == '0) begin rel_steps = k; break; end
    end
  endtask

  initial begin
    int dones;
    int rel;
    int lat;
    logic [N-1:0] exp_g;

    resetn = 1'b0; req_en = '0; req_note = '0;
    step(); step();
    chk("reset_grant", 32'(grant_o), 32'd0);
    chk("reset_note", 32'(note_o), 32'd0);
    #3 resetn = 1'b1;
    step();

    // Single requester 1 with note 8
    req_note[7*1 +: 7] = 7'h08;
    req_en[1] = 1'b1;
    step();
    chk("single_grant", 32'(grant_o), 32'b0010);
    step();
    chk("single_note", 32'(note_o), 32'h08);
    chk("single_valid", 32'(note_valid_o), 32'd1);
    lat = -1;
    for (int k = 3; k <= 40; k++) begin
      step();
      if (counter_done_o[1]) begin lat = k; break; end
    end
    chk("single_done_cycle", 32'(lat), 32'(NC));
    req_en[1] = 1'b0;
    for (int k = 0; k < RG + 2; k++) step();

    // Eight-note jingle on requester 1
    run_jingle(1, 8, dones, rel);
    chk("eight_done_count", 32'(dones), 32'd8);
    chk("eight_release", 32'(rel), 32'(RG));

    // Requesters 2 and 3 together: 2 wins, 3 stalls, then 3 after one idle cycle
    req_note[7*2 +: 7] = 7'h15;
    req_note[7*3 +: 7] = 7'h2a;
    req_en[3] = 1'b1;
    run_jingle(2, 2, dones, rel);
    chk("pair_done_count", 32'(dones), 32'd2);
    chk("pair_release", 32'(rel), 32'(RG));
    step();
    chk("pair_grant3", 32'(grant_o), 32'b1000);

    // Requester 3 playing, requester 0 requests mid-note
    step(); step(); step();
    req_note[6:0] = 7'h33;
    req_en[0] = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (counter_done_o[3]) begin lat = k; break; end
    end
    chk("r3_done_seen", 32'(lat >= 0), 32'd1);
    step();
`ifdef AUDIO_ARB_PREEMPT_EN
    exp_g = 4'b0001;
`else
    exp_g = 4'b1000;
`endif
    chk("preempt_grant", 32'(grant_o), 32'(exp_g));
    req_en[3] = 1'b0;
    for (int k = 0; k < RG + 1; k++) step();
    chk("r0_granted", 32'(grant_o), 32'b0001);
    req_en = '0;
    for (int k = 0; k < RG + 2; k++) step();

    // Short enable drop keeps the grant and restarts note timing
    req_en[1] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    req_en[1] = 1'b0;
    for (int k = 0; k < RG - 1; k++) begin
      step();
      chk("gap_hold", 32'(grant_o), 32'b0010);
    end
    req_en[1] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (counter_done_o[1]) begin lat = k; break; end
    end
    chk("gap_restart", 32'(lat), 32'(NC));
    req_en = '0;
    for (int k = 0; k < RG + 2; k++) step();

    // Asynchronous reset mid-note at count 5
    req_en[2] = 1'b1;
    for (int k = 0; k < 6; k++) step();
    #2 resetn = 1'b0;
    #1;
    chk("arst_grant", 32'(grant_o), 32'd0);
    chk("arst_done", 32'(counter_done_o), 32'd0);
    chk("arst_note", 32'(note_o), 32'd0);
    chk("arst_valid", 32'(note_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    req_en = '0;
    step(); step();
    #3 resetn = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("post_reset_idle", 32'(busy_o), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req_en[k] ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 5) == 0))
          req_en[k] = ~req_en[k];
        if ($urandom_range(0, 15) == 0) req_note[7*k +: 7] = 7'($urandom);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
